// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with an integrated
// busy scoreboard. NR combinational read ports, two write ports (A = ALU
// writeback, B = load/long-latency writeback). Register 0 reads as zero and is
// never busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding on reads.
module regfile_mp #(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NR    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite,
    input  logic [AW-1:0]   WriteReg,
    input  logic [N-1:0]    WriteData,
    input  logic            RegWriteB,
    input  logic [AW-1:0]   WriteRegB,
    input  logic [N-1:0]    WriteDataB,
    input  logic [NR*AW-1:0] ReadReg,
    output logic [NR*N-1:0] ReadData,
    output logic [NR-1:0]   ReadBusy,
    input  logic            IssueValid,
    input  logic [AW-1:0]   IssueReg,
    output logic            AnyBusy
);

    if (AW != $clog2(DEPTH) || DEPTH < 2 || NR < 1 || NR > 4) begin : gBadParams
        $error("regfile_mp: AW must equal log2(DEPTH), DEPTH >= 2, NR in 1..4");
    end

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    // Register array: async clear; port B is applied first so port A wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset because software relies on every register
            // reading 0 after reset, which rules out mapping it onto a plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; when both ports hit the same address
            // the later (port A) assignment is the one that takes effect.
            if (RegWriteB && WriteRegB != '0) begin
                regs[WriteRegB] <= WriteDataB;
            end
            if (RegWrite && WriteReg != '0) begin
                regs[WriteReg] <= WriteData;
            end
        end
    end

    // Scoreboard next state: issue sets, any retire clears, issue wins a tie.
    always_comb begin
        // NOTE: default assigned first so every path drives busyNext and no latch forms.
        busyNext = busy;
        for (int r = 1; r < DEPTH; r++) begin
            if (IssueValid && IssueReg == AW'(r)) begin
                busyNext[r] = 1'b1;
            end else if ((RegWrite && WriteReg == AW'(r)) ||
                         (RegWriteB && WriteRegB == AW'(r))) begin
                busyNext[r] = 1'b0;
            end
        end
        busyNext[0] = 1'b0;
    end

    // Scoreboard state register with async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign AnyBusy = |busy[DEPTH-1:1];

    for (genvar k = 0; k < NR; k++) begin : gRead
        logic [AW-1:0] addr;
        logic [N-1:0]  rdData;
        logic          rdBusy;

        assign addr = ReadReg[k*AW +: AW];

        // Read port k: stored value and busy flag, optionally forwarded from a live write.
        always_comb begin
            rdData = regs[addr];
            rdBusy = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (!rst && addr != '0) begin
                if (RegWrite && WriteReg == addr) begin
                    rdData = WriteData;
                    rdBusy = 1'b0;
                end else if (RegWriteB && WriteRegB == addr) begin
                    rdData = WriteDataB;
                    rdBusy = 1'b0;
                end
            end
`endif
            if (addr == '0) begin
                rdData = '0;
                rdBusy = 1'b0;
            end
        end

        assign ReadData[k*N +: N] = rdData;
        assign ReadBusy[k]        = rdBusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp. Directed vector table,
// hand-written reset/bypass/parametrisation sequences, then randomized traffic
// against a behavioural model of the register file and scoreboard.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int N = 32, DEPTH = 32, AW = 5, NR = 2;
    localparam int N2 = 16, DEPTH2 = 8, AW2 = 3, NR2 = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic            RegWrite, RegWriteB, IssueValid, AnyBusy;
    logic [AW-1:0]   WriteReg, WriteRegB, IssueReg;
    logic [N-1:0]    WriteData, WriteDataB;
    logic [NR*AW-1:0] ReadReg;
    logic [NR*N-1:0] ReadData;
    logic [NR-1:0]   ReadBusy;

    logic             p2RegWrite, p2RegWriteB, p2IssueValid, p2AnyBusy;
    logic [AW2-1:0]   p2WriteReg, p2WriteRegB, p2IssueReg;
    logic [N2-1:0]    p2WriteData, p2WriteDataB;
    logic [NR2*AW2-1:0] p2ReadReg;
    logic [NR2*N2-1:0] p2ReadData;
    logic [NR2-1:0]   p2ReadBusy;

    regfile_mp #(.N(N), .DEPTH(DEPTH), .AW(AW), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .RegWriteB(RegWriteB), .WriteRegB(WriteRegB), .WriteDataB(WriteDataB),
        .ReadReg(ReadReg), .ReadData(ReadData), .ReadBusy(ReadBusy),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .AnyBusy(AnyBusy)
    );

    regfile_mp #(.N(N2), .DEPTH(DEPTH2), .AW(AW2), .NR(NR2)) dut2 (
        .clk(clk), .rst(rst),
        .RegWrite(p2RegWrite), .WriteReg(p2WriteReg), .WriteData(p2WriteData),
        .RegWriteB(p2RegWriteB), .WriteRegB(p2WriteRegB), .WriteDataB(p2WriteDataB),
        .ReadReg(p2ReadReg), .ReadData(p2ReadData), .ReadBusy(p2ReadBusy),
        .IssueValid(p2IssueValid), .IssueReg(p2IssueReg), .AnyBusy(p2AnyBusy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural register contents and pending-write set.
    logic [N-1:0]     mRegs [DEPTH];
    bit   [DEPTH-1:0] mBusy;

    typedef struct {
        logic          rw;
        logic [AW-1:0] wr;
        logic [N-1:0]  wd;
        logic          rwb;
        logic [AW-1:0] wrb;
        logic [N-1:0]  wdb;
        logic          iv;
        logic [AW-1:0] ir;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [N-1:0]  e0;
        logic [N-1:0]  e1;
        logic [1:0]    eb;
        logic          ea;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mRegs[i] = '0;
        mBusy = '0;
    endtask

    // Architectural effect of one clock edge, from the rules: stored data (A beats B),
    // retirements free their register, an issue (applied last) marks it pending again.
    task automatic modelEdge();
        if (rst) begin
            modelReset();
        end else begin
            if (RegWriteB && WriteRegB != 0) mRegs[WriteRegB] = WriteDataB;
            if (RegWrite && WriteReg != 0)   mRegs[WriteReg]  = WriteData;
            if (RegWrite)  mBusy[WriteReg]  = 1'b0;
            if (RegWriteB) mBusy[WriteRegB] = 1'b0;
            if (IssueValid) mBusy[IssueReg] = 1'b1;
            mBusy[0] = 1'b0;
        end
    endtask

    function automatic logic [N-1:0] expData(input logic [AW-1:0] a);
        if (rst || a == 0) return '0;
        if (BYPASS && RegWrite && WriteReg == a) return WriteData;
        if (BYPASS && RegWriteB && WriteRegB == a) return WriteDataB;
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (rst || a == 0) return 1'b0;
        if (BYPASS && ((RegWrite && WriteReg == a) || (RegWriteB && WriteRegB == a))) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic checkModel(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s data%0d", tag, k), ReadData[k*N +: N], expData(ReadReg[k*AW +: AW]));
            check($sformatf("%s busy%0d", tag, k), ReadBusy[k], expBusy(ReadReg[k*AW +: AW]));
        end
        check($sformatf("%s anyBusy", tag), AnyBusy, (!rst && mBusy != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle();
        RegWrite = 0; WriteReg = '0; WriteData = '0;
        RegWriteB = 0; WriteRegB = '0; WriteDataB = '0;
        IssueValid = 0; IssueReg = '0;
    endtask

    task automatic idle2();
        p2RegWrite = 0; p2WriteReg = '0; p2WriteData = '0;
        p2RegWriteB = 0; p2WriteRegB = '0; p2WriteDataB = '0;
        p2IssueValid = 0; p2IssueReg = '0; p2ReadReg = '0;
    endtask

    task automatic setRead(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        ReadReg = {r1, r0};
    endtask

    initial begin
        // Directed vectors: each row's reads see state from the rows before it.
        vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd0,  32'h12345678, 32'h0,        2'b00, 1'b0};
        vecs[2]  = '{1'b1, 5'd7,  32'hA,        1'b1, 5'd7,  32'hB,        1'b0, 5'd0, 5'd0,  5'd3,  32'h0,        32'h12345678, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 5'd8,  32'hA,        1'b1, 5'd9,  32'hB,        1'b0, 5'd0, 5'd7,  5'd0,  32'hA,        32'h0,        2'b00, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 5'd8,  5'd9,  32'hA,        32'hB,        2'b00, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd4,  5'd7,  32'h0,        32'hA,        2'b01, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,       1'b0, 5'd0, 5'd9,  5'd8,  32'hB,        32'hA,        2'b00, 1'b1};
        vecs[7]  = '{1'b1, 5'd4,  32'h77,       1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 5'd3,  5'd9,  32'h12345678, 32'hB,        2'b00, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd4,  5'd0,  32'h77,       32'h0,        2'b01, 1'b1};
        vecs[9]  = '{1'b1, 5'd4,  32'h99,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd3,  32'h0,        32'h12345678, 2'b00, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd4,  5'd4,  32'h99,       32'h99,       2'b00, 1'b0};
        vecs[11] = '{1'b1, 5'd31, 32'hCAFE0001, 1'b1, 5'd30, 32'h0BAD0002, 1'b0, 5'd0, 5'd4,  5'd7,  32'h99,       32'hA,        2'b00, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd30, 32'hCAFE0001, 32'h0BAD0002, 2'b00, 1'b0};

        // Power-on reset.
        rst = 1'b1;
        idle(); idle2(); setRead(5'd1, 5'd31);
        modelReset();
        @(negedge clk); #1;
        check("reset data", ReadData, '0);
        check("reset busy", ReadBusy, '0);
        check("reset anyBusy", AnyBusy, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checkModel("after reset");

        // Second configuration: 16-bit x 8 registers, three read ports.
        p2RegWrite = 1; p2WriteReg = 3'd1; p2WriteData = 16'h1111;
        p2RegWriteB = 1; p2WriteRegB = 3'd4; p2WriteDataB = 16'h4444;
        tick();
        idle2();
        p2RegWrite = 1; p2WriteReg = 3'd7; p2WriteData = 16'h7777;
        tick();
        idle2();
        p2ReadReg = {3'd7, 3'd4, 3'd1};
        p2IssueValid = 1; p2IssueReg = 3'd7;
        #1;
        check("p2 three ports", p2ReadData, {16'h7777, 16'h4444, 16'h1111});
        check("p2 busy before issue", p2ReadBusy, 3'b000);
        tick();
        p2IssueValid = 0;
        #1;
        check("p2 busy port2", p2ReadBusy, 3'b100);
        check("p2 anyBusy", p2AnyBusy, 1'b1);
        p2RegWrite = 1; p2WriteReg = 3'd7; p2WriteData = 16'h0007;
        tick();
        idle2();

        // Table-driven directed vectors.
        for (int i = 0; i < 13; i++) begin
            RegWrite = vecs[i].rw;  WriteReg = vecs[i].wr;  WriteData = vecs[i].wd;
            RegWriteB = vecs[i].rwb; WriteRegB = vecs[i].wrb; WriteDataB = vecs[i].wdb;
            IssueValid = vecs[i].iv; IssueReg = vecs[i].ir;
            setRead(vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("vec%0d data0", i), ReadData[N-1:0], vecs[i].e0);
            check($sformatf("vec%0d data1", i), ReadData[2*N-1:N], vecs[i].e1);
            check($sformatf("vec%0d busy", i), ReadBusy, vecs[i].eb);
            check($sformatf("vec%0d anyBusy", i), AnyBusy, vecs[i].ea);
            tick();
        end
        idle();

        // Asynchronous reset mid-cycle discards data and busy state.
        RegWrite = 1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        IssueValid = 1; IssueReg = 5'd5;
        setRead(5'd0, 5'd0);
        tick();
        idle();
        setRead(5'd5, 5'd0);
        #1;
        check("pre-reset reg5", ReadData[N-1:0], 32'hDEADBEEF);
        check("pre-reset busy", ReadBusy, 2'b01);
        check("pre-reset anyBusy", AnyBusy, 1'b1);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        check("async reset reg5", ReadData[N-1:0], 32'h0);
        check("async reset busy", ReadBusy, 2'b00);
        check("async reset anyBusy", AnyBusy, 1'b0);
        RegWrite = 1; WriteReg = 5'd5; WriteData = 32'h1;
        IssueValid = 1; IssueReg = 5'd5;
        #1;
        check("reset gated data", ReadData[N-1:0], 32'h0);
        tick();
        #1;
        check("no write in reset", ReadData[N-1:0], 32'h0);
        check("no issue in reset", AnyBusy, 1'b0);
        rst = 1'b0;
        idle();
        #1;
        checkModel("post reset");

        // Same-cycle write/read overlap: forwarded with bypass, stale without.
        IssueValid = 1; IssueReg = 5'd6;
        tick();
        idle();
        RegWrite = 1; WriteReg = 5'd6; WriteData = 32'h55;
        setRead(5'd0, 5'd6);
        #1;
        check("overlap data1", ReadData[2*N-1:N], BYPASS ? 32'h55 : 32'h0);
        check("overlap busy", ReadBusy, BYPASS ? 2'b00 : 2'b10);
        tick();
        idle();
        #1;
        check("overlap landed", ReadData[2*N-1:N], 32'h55);
        check("overlap busy cleared", ReadBusy, 2'b00);
        RegWrite = 1; WriteReg = 5'd10; WriteData = 32'h1111;
        RegWriteB = 1; WriteRegB = 5'd10; WriteDataB = 32'h2222;
        setRead(5'd10, 5'd10);
        #1;
        check("bypass priority", ReadData, BYPASS ? {32'h1111, 32'h1111} : 64'h0);
        tick();
        idle();
        RegWriteB = 1; WriteRegB = 5'd11; WriteDataB = 32'h3333;
        setRead(5'd10, 5'd11);
        #1;
        check("bypass port B", ReadData, BYPASS ? {32'h3333, 32'h1111} : {32'h0, 32'h1111});
        tick();
        idle();
        #1;
        checkModel("after overlap");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (rst) modelReset();
            RegWrite   = $urandom_range(0, 1);
            WriteReg   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            WriteData  = $urandom;
            RegWriteB  = $urandom_range(0, 1);
            WriteRegB  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            WriteDataB = $urandom;
            IssueValid = $urandom_range(0, 1);
            IssueReg   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            setRead(AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
            #1;
            checkModel($sformatf("rand%0d", c));
            tick();
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
